alarm_denetleyici: RTL

- Building-level alarm controller downstream of the per-floor `kat_alarmi` blocks. It consumes one `alarm` bit per floor.
- Qualifies alarms by persistence, then latches them.
- Drives a pulsed siren and a steady beacon, records the first floor in alarm, and runs an operator acknowledge/clear handshake with re-arm on new floors.

---
 rtl/alarm_denetleyici_pkg.sv | 20 ++
 rtl/alarm_denetleyici_oncelik_kodlayici.sv | 34 +++
 rtl/alarm_denetleyici.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alarm_denetleyici_pkg.sv
// Shared types and defaults for the building alarm controller: state encoding,
// default timing constants and the floor-index width helper.
package alarm_pkg;

   typedef enum logic [1:0] {
      BEKLE     = 2'd0,
      DOGRULA   = 2'd1,
      ALARM     = 2'd2,
      ONAYLANDI = 2'd3
   } durum_t;

   localparam int VARSAYILAN_DOGRULAMA   = 16;
   localparam int VARSAYILAN_SIREN_YARIM = 8;

   // A single-floor build still needs a one-bit index port.
   function automatic int kat_genisligi(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alarm_denetleyici_oncelik_kodlayici.sv
// Lowest-set-bit encoder: returns the index of the lowest high bit of giris,
// or 0 when no bit is set.
module oncelik_kodlayici
   import alarm_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] giris,
   output logic [W-1:0] indeks
);

   logic [N-1:0] ilk_bit;

   // One-hot mask of the lowest set bit; at most one bit is ever high.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_ilk
         if (gi == 0) begin : g_sifir
            assign ilk_bit[gi] = giris[gi];
         end else begin : g_diger
            assign ilk_bit[gi] = giris[gi] & ~(|giris[gi-1:0]);
         end
      end
   endgenerate

   always_comb begin
      indeks = '0;
      for (int i = 0; i < N; i++) begin
         if (ilk_bit[i]) indeks = indeks | W'(i);
      end
   end

endmodule

// File: rtl/alarm_denetleyici.sv
// Building alarm controller: persistence check, latching, siren/beacon drive and
// acknowledge/clear handshake. Define KAT_SENKRON_EN to add 2-flop input synchronizers.
module alarm_denetleyici
   import alarm_pkg::*;
#(
   parameter int  KAT_SAYISI  = 4,
   parameter int  DOGRULAMA   = VARSAYILAN_DOGRULAMA,
   parameter int  SIREN_YARIM = VARSAYILAN_SIREN_YARIM,
   localparam int KW          = kat_genisligi(KAT_SAYISI)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [KAT_SAYISI-1:0] kat_alarm,
   input  logic                  onay,
   input  logic                  sifirla,
   output logic                  siren,
   output logic                  isik,
   output logic [KW-1:0]         ilk_kat,
   output logic [KAT_SAYISI-1:0] aktif_maske,
   output logic [1:0]            durum
);

   localparam int DW = $clog2(DOGRULAMA + 1);
   localparam int SW = (SIREN_YARIM > 1) ? $clog2(SIREN_YARIM) : 1;

   logic [KAT_SAYISI-1:0] kat_s;
   logic                  onay_s;
   logic                  sifirla_s;

`ifdef KAT_SENKRON_EN
   logic [KAT_SAYISI-1:0] kat_ara_reg;
   logic [KAT_SAYISI-1:0] kat_sync_reg;
   logic [1:0]            onay_sync_reg;
   logic [1:0]            sifirla_sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kat_ara_reg      <= '0;
         kat_sync_reg     <= '0;
         onay_sync_reg    <= '0;
         sifirla_sync_reg <= '0;
      end else begin
         kat_ara_reg      <= kat_alarm;
         kat_sync_reg     <= kat_ara_reg;
         onay_sync_reg    <= {onay_sync_reg[0], onay};
         sifirla_sync_reg <= {sifirla_sync_reg[0], sifirla};
      end
   end

   assign kat_s     = kat_sync_reg;
   assign onay_s    = onay_sync_reg[1];
   assign sifirla_s = sifirla_sync_reg[1];
`else
   assign kat_s     = kat_alarm;
   assign onay_s    = onay;
   assign sifirla_s = sifirla;
`endif

   logic [KW-1:0] ilk_kat_next;

   oncelik_kodlayici #(
      .N (KAT_SAYISI),
      .W (KW)
   ) u_oncelik (
      .giris  (kat_s),
      .indeks (ilk_kat_next)
   );

   durum_t                durum_reg;
   logic [DW-1:0]         dog_cnt_reg;
   logic [SW-1:0]         siren_cnt_reg;
   logic                  siren_reg;
   logic                  isik_reg;
   logic [KW-1:0]         ilk_kat_reg;
   logic [KAT_SAYISI-1:0] maske_reg;

   logic                  hot;
   logic [KAT_SAYISI-1:0] yeni_kat;

   assign hot      = |kat_s;
   assign yeni_kat = kat_s & ~maske_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         durum_reg     <= BEKLE;
         dog_cnt_reg   <= '0;
         siren_cnt_reg <= '0;
         siren_reg     <= 1'b0;
         isik_reg      <= 1'b0;
         ilk_kat_reg   <= '0;
         maske_reg     <= '0;
      end else begin
         case (durum_reg)
            BEKLE: begin
               if (hot) begin
                  if (DOGRULAMA == 1) begin
                     durum_reg     <= ALARM;
                     dog_cnt_reg   <= '0;
                     ilk_kat_reg   <= ilk_kat_next;
                     maske_reg     <= kat_s;
                     isik_reg      <= 1'b1;
                     siren_reg     <= 1'b1;
                     siren_cnt_reg <= '0;
                  end else begin
                     durum_reg   <= DOGRULA;
                     dog_cnt_reg <= DW'(1);
                  end
               end
            end
            DOGRULA: begin
               if (!hot) begin
                  durum_reg   <= BEKLE;
                  dog_cnt_reg <= '0;
               end else if (dog_cnt_reg == DW'(DOGRULAMA - 1)) begin
                  // This edge samples the last required hot cycle.
                  durum_reg     <= ALARM;
                  dog_cnt_reg   <= '0;
                  ilk_kat_reg   <= ilk_kat_next;
                  maske_reg     <= kat_s;
                  isik_reg      <= 1'b1;
                  siren_reg     <= 1'b1;
                  siren_cnt_reg <= '0;
               end else begin
                  dog_cnt_reg <= dog_cnt_reg + 1'b1;
               end
            end
            ALARM: begin
               maske_reg <= maske_reg | kat_s;
               if (onay_s) begin
                  durum_reg     <= ONAYLANDI;
                  siren_reg     <= 1'b0;
                  siren_cnt_reg <= '0;
               end else if (siren_cnt_reg == SW'(SIREN_YARIM - 1)) begin
                  siren_cnt_reg <= '0;
                  siren_reg     <= ~siren_reg;
               end else begin
                  siren_cnt_reg <= siren_cnt_reg + 1'b1;
               end
            end
            ONAYLANDI: begin
               siren_reg <= 1'b0;
               // A newly alarming floor re-arms without reconfirmation and beats a clear.
               if (|yeni_kat) begin
                  durum_reg     <= ALARM;
                  maske_reg     <= maske_reg | kat_s;
                  siren_reg     <= 1'b1;
                  siren_cnt_reg <= '0;
               end else if (sifirla_s && !hot) begin
                  durum_reg   <= BEKLE;
                  maske_reg   <= '0;
                  isik_reg    <= 1'b0;
                  dog_cnt_reg <= '0;
               end
            end
            default: durum_reg <= BEKLE;
         endcase
      end
   end

   assign siren       = siren_reg;
   assign isik        = isik_reg;
   assign ilk_kat     = ilk_kat_reg;
   assign aktif_maske = maske_reg;
   assign durum       = durum_reg;

endmodule
